// File: rtl/sc_lsu_pkg.sv
// sc_lsu_pkg: shared definitions for the load/store unit.
// Holds the access-size encodings, the FSM state type, byte/half lane
// masks and the alignment test used when the misalignment trap is built in.
package sc_lsu_pkg;

  localparam int unsigned DATA_W = 32;

  // Access size encodings; both 2'b10 and 2'b11 mean word.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCESS = 3'd1,
    ST_LOAD   = 3'd2,
    ST_MERGE  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Lane masks, right-aligned; shifted into place by the byte offset.
  localparam logic [DATA_W-1:0] LANE_MASK_BYTE = 32'h0000_00FF;
  localparam logic [DATA_W-1:0] LANE_MASK_HALF = 32'h0000_FFFF;
  localparam logic [DATA_W-1:0] LANE_MASK_WORD = 32'hFFFF_FFFF;

  // Half needs addr[0]=0, word needs addr[1:0]=0; bytes are always aligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    is_misaligned = ((size == SZ_HALF) && lane[0]) || (size[1] && (lane != 2'b00));
  endfunction

endpackage

// File: rtl/sc_lsu_lane.sv
// sc_lsu_lane: combinational lane logic for the load/store unit.
// Ports:
//   size_i       access size (byte/half/word)
//   lane_i       byte offset within the word (addr[1:0])
//   sign_ext_i   1 = sign-extend loaded byte/half
//   rword_i      word read from RAM
//   wdata_i      store data (low bits used for sub-word stores)
//   load_data_c  extracted and extended load result
//   merge_data_c rword_i with the addressed lane replaced by wdata_i
module sc_lsu_lane
  import sc_lsu_pkg::*;
(
  input  logic [1:0]        size_i,
  input  logic [1:0]        lane_i,
  input  logic              sign_ext_i,
  input  logic [DATA_W-1:0] rword_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] load_data_c,
  output logic [DATA_W-1:0] merge_data_c
);

  logic [4:0]        shamt;
  logic [DATA_W-1:0] mask;
  logic [DATA_W-1:0] lane_mask;
  logic [DATA_W-1:0] shifted;

  // Bit offset and mask of the addressed lane; halves ignore addr[0].
  always_comb begin
    shamt = 5'd0;
    mask  = LANE_MASK_WORD;
    case (size_i)
      SZ_BYTE: begin
        shamt = {lane_i, 3'b000};
        mask  = LANE_MASK_BYTE;
      end
      SZ_HALF: begin
        shamt = {lane_i[1], 4'b0000};
        mask  = LANE_MASK_HALF;
      end
      default: begin
        shamt = 5'd0;
        mask  = LANE_MASK_WORD;
      end
    endcase
  end

  assign shifted   = rword_i >> shamt;
  assign lane_mask = mask << shamt;

  // Load path: right-align the lane, then sign- or zero-extend.
  always_comb begin
    load_data_c = rword_i;
    case (size_i)
      SZ_BYTE: load_data_c = sign_ext_i ? {{24{shifted[7]}}, shifted[7:0]}
                                        : {24'd0, shifted[7:0]};
      SZ_HALF: load_data_c = sign_ext_i ? {{16{shifted[15]}}, shifted[15:0]}
                                        : {16'd0, shifted[15:0]};
      default: load_data_c = rword_i;
    endcase
  end

  // Store path: keep the untouched lanes, insert the new one.
  assign merge_data_c = (rword_i & ~lane_mask) | ((wdata_i << shamt) & lane_mask);

endmodule

// File: rtl/sc_lsu.sv
// sc_lsu: load/store unit between the CPU and the word-wide data RAM.
// Byte/half/word loads are lane-extracted and extended; sub-word stores
// are a read-modify-write. busy stalls the CPU while an access runs.
// Optional macro SC_LSU_MISALIGN_TRAP_EN: misaligned half/word accesses
// skip the RAM and complete with misalign=1; otherwise they are truncated.
// Ports:
//   clock, reset      clock and synchronous active-high reset
//   req, wr, size, sign_ext, addr, wdata   CPU request (sampled in IDLE)
//   busy, done, rdata, misalign            CPU status / load result
//   ram_addr, ram_din, ram_we, ram_dout    data RAM port (registered read)
module sc_lsu
  import sc_lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              misalign,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam int unsigned CAP_W = ADDR_W + 2;

  state_e            state_q, state_d;
  logic [CAP_W-1:0]  addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              wr_q, wr_d;
  logic              sext_q, sext_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              misalign_q, misalign_d;

  logic              we_c;
  logic              trap_c;
  logic [DATA_W-1:0] din_c;
  logic [DATA_W-1:0] load_data_c;
  logic [DATA_W-1:0] merge_data_c;

  // Address bits above the RAM range are not used.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[DATA_W-1:CAP_W];

`ifdef SC_LSU_MISALIGN_TRAP_EN
  assign trap_c = is_misaligned(size_q, addr_q[1:0]);
`else
  assign trap_c = 1'b0;
`endif

  sc_lsu_lane u_lane (
    .size_i       (size_q),
    .lane_i       (addr_q[1:0]),
    .sign_ext_i   (sext_q),
    .rword_i      (ram_dout),
    .wdata_i      (wdata_q),
    .load_data_c  (load_data_c),
    .merge_data_c (merge_data_c)
  );

  // State and capture registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      size_q     <= SZ_BYTE;
      wr_q       <= 1'b0;
      sext_q     <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      wr_q       <= wr_d;
      sext_q     <= sext_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
    end
  end

  // Next-state and RAM control.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    size_d     = size_q;
    wr_d       = wr_q;
    sext_d     = sext_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    misalign_d = misalign_q;
    we_c       = 1'b0;
    din_c      = wdata_q;

    case (state_q)
      ST_IDLE: begin
        misalign_d = 1'b0;
        if (req) begin
          addr_d  = addr[CAP_W-1:0];
          size_d  = size;
          wr_d    = wr;
          sext_d  = sign_ext;
          wdata_d = wdata;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        misalign_d = trap_c;
        if (trap_c) begin
          state_d = ST_DONE;
        end else if (wr_q && size_q[1]) begin
          // Word store writes directly; no read needed.
          we_c    = 1'b1;
          state_d = ST_DONE;
        end else if (!wr_q) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_MERGE;
        end
      end
      ST_LOAD: begin
        rdata_d = load_data_c;
        state_d = ST_DONE;
      end
      ST_MERGE: begin
        we_c    = 1'b1;
        din_c   = merge_data_c;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign rdata    = rdata_q;
  assign misalign = misalign_q;
  assign ram_addr = addr_q[CAP_W-1:2];
  assign ram_din  = din_c;
  // Reset must suppress any write in the cycle it is asserted.
  assign ram_we   = we_c & ~reset;

endmodule

// File: tb/tb_sc_lsu.sv
// tb_sc_lsu: self-checking bench for sc_lsu with a word RAM and a
// byte-addressed reference memory model.
module tb_sc_lsu;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned NWORDS = 32;

  logic        clock;
  logic        reset;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        misalign;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0] ram_din;
  logic        ram_we;
  logic [31:0] ram_dout;
  logic        mem_clr;

  logic [31:0] mem [NWORDS];
  logic [7:0]  rb  [NWORDS*4];
  logic [31:0] exp_rdata;

  int n_vec;
  int n_fail;

  sc_lsu #(.ADDR_W(ADDR_W)) dut (
    .clock    (clock),
    .reset    (reset),
    .req      (req),
    .wr       (wr),
    .size     (size),
    .sign_ext (sign_ext),
    .addr     (addr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .rdata    (rdata),
    .misalign (misalign),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_we   (ram_we),
    .ram_dout (ram_dout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Data RAM with registered read.
  always @(posedge clock) begin
    if (mem_clr) begin
      for (int i = 0; i < NWORDS; i++) mem[i] <= 32'd0;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_din;
    end
    ram_dout <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic ref_mis(input logic [1:0] sz, input logic [31:0] a);
`ifdef SC_LSU_MISALIGN_TRAP_EN
    return ((sz == 2'b01) && a[0]) || (sz[1] && (a[1:0] != 2'b00));
`else
    return 1'b0;
`endif
  endfunction

  function automatic int unsigned ref_nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_word(input int unsigned wa);
    return {rb[wa*4+3], rb[wa*4+2], rb[wa*4+1], rb[wa*4]};
  endfunction

  // Little-endian byte store; the address is rounded down to the access size.
  task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int unsigned n, base;
    n = ref_nbytes(sz);
    base = (a % (NWORDS*4)) / n * n;
    for (int k = 0; k < n; k++) rb[base+k] = wd[8*k +: 8];
  endtask

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic se, input logic [31:0] a);
    int unsigned n, base;
    logic [31:0] v;
    n = ref_nbytes(sz);
    base = (a % (NWORDS*4)) / n * n;
    v = 32'd0;
    for (int k = 0; k < n; k++) v = v | (32'(rb[base+k]) << (8*k));
    if (se && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  // One complete transaction, checked against the reference model.
  task automatic run_op(input string tag, input logic w, input logic [1:0] sz, input logic se,
                        input logic [31:0] a, input logic [31:0] wd, input logic hold);
    int cyc, we_cnt, we_cyc, busy_cnt, exp_lat, drain;
    logic [ADDR_W-1:0] we_addr;
    logic got_done, got_mis, exp_mis;
    logic [31:0] got_rd;
    exp_mis = ref_mis(sz, a);
    exp_lat = (exp_mis || (w && sz[1])) ? 2 : 3;
    we_cnt = 0; we_cyc = 0; busy_cnt = 0; got_done = 1'b0; got_mis = 1'b0;
    got_rd = 32'd0; we_addr = '0;

    @(negedge clock);
    req = 1'b1; wr = w; size = sz; sign_ext = se; addr = a; wdata = wd;
    @(negedge clock);
    if (!hold) req = 1'b0;
    cyc = 1;
    while (cyc <= 8) begin
      if (busy) busy_cnt++;
      if (ram_we) begin
        we_cnt++;
        we_cyc = cyc;
        we_addr = ram_addr;
      end
      if (done) begin
        got_done = 1'b1;
        got_mis = misalign;
        got_rd = rdata;
        break;
      end
      @(negedge clock);
      cyc++;
    end

    if (!exp_mis) begin
      if (w) ref_store(sz, a, wd);
      else exp_rdata = ref_load(sz, se, a);
    end

    check({tag, "/done_seen"}, 32'(got_done), 32'd1);
    check({tag, "/latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, "/busy_cycles"}, 32'(busy_cnt), 32'(exp_lat));
    check({tag, "/rdata"}, got_rd, exp_rdata);
    check({tag, "/misalign"}, 32'(got_mis), 32'(exp_mis));
    check({tag, "/we_count"}, 32'(we_cnt), (w && !exp_mis) ? 32'd1 : 32'd0);
    if (we_cnt == 1) begin
      check({tag, "/we_addr"}, 32'(we_addr), 32'(a[ADDR_W+1:2]));
      check({tag, "/we_cycle"}, 32'(we_cyc), 32'(exp_lat - 1));
    end
    check({tag, "/mem_word"}, mem[a[ADDR_W+1:2]], ref_word(32'(a[ADDR_W+1:2])));

    if (hold) begin
      // req still high: one IDLE cycle, then exactly one new acceptance.
      @(negedge clock);
      check({tag, "/idle_gap"}, 32'(busy), 32'd0);
      @(negedge clock);
      check({tag, "/reaccept"}, 32'(busy), 32'd1);
      req = 1'b0;
      drain = 0;
      while (busy && drain < 10) begin
        @(negedge clock);
        drain++;
      end
      check({tag, "/drain"}, 32'(busy), 32'd0);
      if (!exp_mis && !w) exp_rdata = ref_load(sz, se, a);
      check({tag, "/reload"}, rdata, exp_rdata);
    end
  endtask

  initial begin
    n_vec = 0;
    n_fail = 0;
    exp_rdata = 32'd0;
    reset = 1'b1; mem_clr = 1'b1;
    req = 1'b0; wr = 1'b0; size = 2'b00; sign_ext = 1'b0; addr = 32'd0; wdata = 32'd0;
    for (int i = 0; i < NWORDS*4; i++) rb[i] = 8'd0;

    repeat (3) @(negedge clock);
    check("rst/busy", 32'(busy), 32'd0);
    check("rst/done", 32'(done), 32'd0);
    check("rst/rdata", rdata, 32'd0);
    check("rst/misalign", 32'(misalign), 32'd0);
    check("rst/ram_we", 32'(ram_we), 32'd0);
    reset = 1'b0; mem_clr = 1'b0;

    // Word store then load.
    run_op("wst", 1'b1, 2'b10, 1'b0, 32'h08, 32'hDEADBEEF, 1'b0);
    run_op("wld", 1'b0, 2'b10, 1'b0, 32'h08, 32'd0, 1'b0);
    check("wld/const", rdata, 32'hDEADBEEF);

    // Byte read-modify-write.
    run_op("pre0c", 1'b1, 2'b10, 1'b0, 32'h0C, 32'h11223344, 1'b0);
    run_op("bst", 1'b1, 2'b00, 1'b0, 32'h0D, 32'h000000AA, 1'b0);
    check("bst/const", mem[3], 32'h1122AA44);

    // Signed and unsigned sub-word loads.
    run_op("pre10", 1'b1, 2'b10, 1'b0, 32'h10, 32'h8000FF7F, 1'b0);
    run_op("lbs", 1'b0, 2'b00, 1'b1, 32'h11, 32'd0, 1'b0);
    check("lbs/const", rdata, 32'hFFFFFFFF);
    run_op("lbu", 1'b0, 2'b00, 1'b0, 32'h11, 32'd0, 1'b0);
    check("lbu/const", rdata, 32'h000000FF);
    run_op("lhs", 1'b0, 2'b01, 1'b1, 32'h12, 32'd0, 1'b0);
    check("lhs/const", rdata, 32'hFFFF8000);

    // Misaligned word store.
    run_op("mis", 1'b1, 2'b10, 1'b0, 32'h15, 32'hCAFEF00D, 1'b0);
`ifdef SC_LSU_MISALIGN_TRAP_EN
    check("mis/const", mem[5], 32'h00000000);
`else
    check("mis/const", mem[5], 32'hCAFEF00D);
`endif

    // req held high across a load.
    run_op("hold", 1'b0, 2'b10, 1'b0, 32'h08, 32'd0, 1'b1);

    // Reset during MERGE of a half store.
    @(negedge clock);
    req = 1'b1; wr = 1'b1; size = 2'b01; sign_ext = 1'b0; addr = 32'h12; wdata = 32'h00005555;
    @(negedge clock);
    req = 1'b0;
    @(negedge clock);
    check("rstm/we_before", 32'(ram_we), 32'd1);
    reset = 1'b1;
    #1;
    check("rstm/we_gated", 32'(ram_we), 32'd0);
    check("rstm/done", 32'(done), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    exp_rdata = 32'd0;
    check("rstm/busy", 32'(busy), 32'd0);
    check("rstm/done_after", 32'(done), 32'd0);
    check("rstm/mem", mem[4], ref_word(4));
    check("rstm/rdata", rdata, 32'd0);
    run_op("rstm_fresh", 1'b0, 2'b01, 1'b0, 32'h12, 32'd0, 1'b0);

    // Randomized traffic against the reference model.
    for (int t = 0; t < 200; t++) begin
      run_op("rnd", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             32'($urandom_range(0, NWORDS*4 - 1)), $urandom, 1'b0);
    end

    // Final full-memory sweep.
    for (int i = 0; i < NWORDS; i++) check("sweep", mem[i], ref_word(i));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
